byte_serial_adder: RTL and testbench



---
 rtl/byte_serial_adder_if.sv | 30 +++
 rtl/byte_serial_adder.sv | 117 +++++++++++
 tb/tb_byte_serial_adder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serial_adder_if.sv
// byte_serial_adder_if: operand request / result response bundle for the
// byte-serial adder.
//   request : in_valid, in_ready, a, b, cin, sub
//   response: out_valid, out_ready, sum, cout, ovf
// slave is the adder side; master is the producer/consumer side.
interface byte_serial_adder_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;
  logic                  ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: NBYTES-wide add/subtract done one byte per clock,
// LSB first, through a single 8-bit adder. The byte carry is registered and
// fed back into the next byte.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : byte_serial_adder_if.slave
//          in_valid/in_ready + a, b, cin, sub  (accepted only in IDLE)
//          out_valid/out_ready + sum, cout, ovf (held through DONE and IDLE)
// Latency is NBYTES+1 cycles from acceptance; one op per NBYTES+2 cycles.

module eightbitadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = 9'(a) + 9'(b) + 9'(ci);
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_serial_adder_if.slave   bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;      // already inverted for subtract
  logic [W-1:0]    sum_q;
  logic            carry;
  logic            cout_q;
  logic            ovf_q;

  logic [7:0]      add_a, add_b, add_s;
  logic            add_co;
  logic            last;

  assign last  = (idx == IW'(NBYTES - 1));
  assign add_a = op_a[{idx, 3'b000} +: 8];
  assign add_b = op_b[{idx, 3'b000} +: 8];

  eightbitadder u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath. Subtract is folded into the operands at acceptance
  // (B inverted, carry seeded with 1), so the op flag need not be kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q[{idx, 3'b000} +: 8] <= add_s;
          carry                     <= add_co;
          if (last) begin
            cout_q <= add_co;
            // operands agree in sign but the result sign differs
            ovf_q  <= (op_a[W-1] == op_b[W-1]) && (add_s[7] != op_a[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
module tb_byte_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_serial_adder_if #(.NBYTES(4)) bus();
  byte_serial_adder_if #(.NBYTES(2)) bus2();

  byte_serial_adder #(.NBYTES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  byte_serial_adder #(.NBYTES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
    end
  endtask

  // Independent reference: integer add/sub with overflow judged by range
  // of the signed result at width w.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, am, bm, t;
    longint      sa, sb, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    am = a & mask;
    bm = b & mask;
    lim = longint'(64'd1 << (w - 1));
    sa = longint'(am); if (am[w-1]) sa = sa - 2 * lim;
    sb = longint'(bm); if (bm[w-1]) sb = sb - 2 * lim;
    if (sub) begin
      sr = sa - sb;
      co = (am >= bm);
      s  = (am - bm) & mask;
    end else begin
      sr = sa + sb + longint'(cin);
      t  = am + bm + 64'(cin);
      co = t[w];
      s  = t & mask;
    end
    ov = (sr >= lim) || (sr < -lim);
  endfunction

  // Present an op and wait for the accepting edge; scramble the inputs after.
  task automatic accept4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  // Cycle n lies between edges E(n-1) and E(n), acceptance at E0 ends cycle 0,
  // so out_valid visible after k edges is cycle k+1.
  task automatic wait_done4(output int lat);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (!bus.out_valid && k < 50);
    check("done_seen", 64'(bus.out_valid), 64'd1);
    lat = k + 1;
  endtask

  task automatic release4();
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);
    check("rel_in_ready",  64'(bus.in_ready),  64'd1);
  endtask

  task automatic b2b4();
    logic [63:0] es; logic eco, eov;
    logic [31:0] ra, rb; logic rc, rs;
    int t_acc, t_prev, n;
    t_prev = 0;
    @(negedge clk); bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = (k == 1);
      model(32, 64'(ra), 64'(rb), rc, rs, es, eco, eov);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
      n = 0;
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      check("b2b4_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1; t_acc = cyc;
      if (k > 0) check("b2b4_spacing", 64'(t_acc - t_prev), 64'd6);
      t_prev = t_acc;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 50);
      check("b2b4_sum",  64'(bus.sum),  es);
      check("b2b4_cout", 64'(bus.cout), 64'(eco));
      check("b2b4_ovf",  64'(bus.ovf),  64'(eov));
    end
    bus.in_valid = 1'b0;
    @(negedge clk); @(negedge clk); bus.out_ready = 1'b0;
  endtask

  task automatic b2b2();
    logic [63:0] es; logic eco, eov;
    logic [15:0] ra, rb; logic rc, rs;
    int t_acc, t_prev, n;
    t_prev = 0;
    @(negedge clk); bus2.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin ra = 16'h7FFF; rb = 16'h0001; rc = 1'b0; rs = 1'b0; end
      else begin ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = (k == 2); end
      model(16, 64'(ra), 64'(rb), rc, rs, es, eco, eov);
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.a = ra; bus2.b = rb; bus2.cin = rc; bus2.sub = rs;
      n = 0;
      while (!bus2.in_ready && n < 50) begin @(negedge clk); n++; end
      check("b2b2_ready", 64'(bus2.in_ready), 64'd1);
      @(posedge clk); #1; t_acc = cyc;
      if (k > 0) check("b2b2_spacing", 64'(t_acc - t_prev), 64'd4);
      t_prev = t_acc;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus2.out_valid && n < 50);
      if (k == 0) check("b2b2_latency", 64'(n + 1), 64'd3);
      check("b2b2_sum",  64'(bus2.sum),  es);
      check("b2b2_cout", 64'(bus2.cout), 64'(eco));
      check("b2b2_ovf",  64'(bus2.ovf),  64'(eov));
    end
    bus2.in_valid = 1'b0;
    @(negedge clk); @(negedge clk); bus2.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",       64'(bus.sum),       64'd0);
    check("rst_cout",      64'(bus.cout),      64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    @(negedge clk); rst = 1'b0;

    // directed table
    for (int i = 0; i < 7; i++) begin
      accept4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done4(lat);
      check("vec_latency", 64'(lat), 64'd5);
      check("vec_sum",  64'(bus.sum),  64'(vecs[i].s));
      check("vec_cout", 64'(bus.cout), 64'(vecs[i].co));
      check("vec_ovf",  64'(bus.ovf),  64'(vecs[i].ov));
      release4();
    end

    // backpressure, with inputs churning under in_valid while busy
    accept4(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.sub = 1'b1;
    wait_done4(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check("bp_sum",  64'(bus.sum),  64'h1010_1011);
      check("bp_cout", 64'(bus.cout), 64'd0);
      check("bp_ovf",  64'(bus.ovf),  64'd0);
    end
    @(negedge clk); bus.in_valid = 1'b0;
    release4();
    @(posedge clk); #1;
    check("bp_no_extra_op", 64'(bus.in_ready), 64'd1);

    // reset in the second RUN cycle
    accept4(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sum",       64'(bus.sum),       64'd0);
    check("mid_rst_cout",      64'(bus.cout),      64'd0);
    check("mid_rst_ovf",       64'(bus.ovf),       64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk); rst = 1'b0;
    accept4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done4(lat);
    check("post_rst_sum",  64'(bus.sum),  64'h2345_6789);
    check("post_rst_cout", 64'(bus.cout), 64'd0);
    release4();

    b2b4();
    b2b2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
